// File: rtl/main_mem_responder_if.sv
// Request/response bus for main_mem_responder.
// The master issues requests and the slave (the responder) returns read data.
interface main_mem_responder_if;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic        busy;
    logic        align_err;

    modport master (
        output enable, wr, addr, data_in,
        input  data_out, data_valid, busy, align_err
    );

    modport slave (
        input  enable, wr, addr, data_in,
        output data_out, data_valid, busy, align_err
    );
endinterface

// File: rtl/main_mem_responder.sv
// main_mem_responder: 16-bit word memory with a fixed-latency, fully pipelined
// read return path and no backpressure. Writes land at the issue edge. Reads
// sample the array at the issue edge and return LATENCY cycles later.
// Optional feature macro: MEM_ALIGN_CHECK_EN drops odd-address requests and
// pulses align_err for one cycle. Without it, addr[0] is ignored.
module main_mem_responder #(
    parameter int LATENCY = 4,
    parameter int DEPTH_W = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    main_mem_responder_if.slave  bus
);

    logic [15:0]        r_mem [2**DEPTH_W];
    logic [LATENCY-1:0] r_pipe_v;
    logic [15:0]        r_pipe_d [LATENCY];
    logic [15:0]        r_data_out;
    logic               r_data_valid;

    logic [DEPTH_W-1:0] w_idx;
    logic               w_drop;
    logic               w_wr;
    logic               w_rd;
    logic               w_unused_addr;

    assign w_idx         = bus.addr[DEPTH_W:1];
    assign w_unused_addr = ^bus.addr;

`ifdef MEM_ALIGN_CHECK_EN
    logic r_align_err;

    assign w_drop = bus.enable & bus.addr[0];

    // Flag a dropped odd-address request one cycle after it is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_align_err <= 1'b0;
        end else begin
            r_align_err <= w_drop;
        end
    end

    assign bus.align_err = r_align_err;
`else
    assign w_drop        = 1'b0;
    assign bus.align_err = 1'b0;
`endif

    // Requests presented during reset are ignored, including writes.
    assign w_wr = ~rst & bus.enable &  bus.wr & ~w_drop;
    assign w_rd = ~rst & bus.enable & ~bus.wr & ~w_drop;

    // Array write port. Contents are deliberately not cleared by reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_idx] <= bus.data_in;
        end
    end

    // Read pipeline: stage 0 captures the array at the issue edge, then the
    // word shifts through LATENCY-1 more stages into the output register.
    // Because stage 0 reads the pre-edge array value, a later write to the
    // same word cannot disturb a read that is already in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe_v     <= '0;
            r_data_valid <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_pipe_v[0] <= w_rd;
            r_pipe_d[0] <= r_mem[w_idx];
            for (int unsigned i = 1; i < unsigned'(LATENCY); i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_d[i] <= r_pipe_d[i-1];
            end
            r_data_valid <= r_pipe_v[LATENCY-1];
            if (r_pipe_v[LATENCY-1]) begin
                r_data_out <= r_pipe_d[LATENCY-1];
            end
        end
    end

    assign bus.data_out   = r_data_out;
    assign bus.data_valid = r_data_valid;
    assign bus.busy       = |r_pipe_v;

endmodule

// File: tb/tb_main_mem_responder.sv
// Self-checking bench for main_mem_responder: table-driven directed vectors,
// hand-written multi-cycle sequences, and randomized traffic checked against
// a queue-based reference model of the memory and its read returns.
module tb_main_mem_responder;

    localparam int L  = 4;
    localparam int DW = 8;

    logic clk;
    logic rst;

    main_mem_responder_if bus ();

    main_mem_responder #(.LATENCY(L), .DEPTH_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    typedef struct {
        int          due;
        logic [15:0] d;
    } rd_t;

    logic [15:0] m_mem [256];
    rd_t         pend [$];
    int          cyc = 0;
    logic        m_valid;
    logic        m_busy;
    logic        m_align;
    logic [15:0] m_dout;

    // Pulse recorder for the multi-cycle sequences.
    logic        rec = 1'b0;
    int          got_cyc [$];
    logic [15:0] got_dat [$];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // Apply one request across one rising edge, advance the model, compare.
    task automatic step(input logic r, input logic e, input logic w,
                        input logic [15:0] a, input logic [15:0] d);
        logic drop;
        logic [7:0] idx;
        @(negedge clk);
        rst         = r;
        bus.enable  = e;
        bus.wr      = w;
        bus.addr    = a;
        bus.data_in = d;
        @(posedge clk);
        cyc++;
        idx = a[8:1];
        if (r) begin
            pend.delete();
            m_valid = 1'b0;
            m_dout  = 16'h0000;
            m_align = 1'b0;
        end else begin
            m_valid = 1'b0;
            if (pend.size() != 0 && pend[0].due == cyc) begin
                m_valid = 1'b1;
                m_dout  = pend[0].d;
                void'(pend.pop_front());
            end
`ifdef MEM_ALIGN_CHECK_EN
            drop = e & a[0];
`else
            drop = 1'b0;
`endif
            m_align = drop;
            if (e && !drop) begin
                if (w) m_mem[idx] = d;
                else   pend.push_back('{due: cyc + L, d: m_mem[idx]});
            end
        end
        m_busy = (pend.size() != 0);
        #1;
        chk("data_valid", {15'd0, bus.data_valid}, {15'd0, m_valid});
        chk("data_out",   bus.data_out,            m_dout);
        chk("busy",       {15'd0, bus.busy},       {15'd0, m_busy});
        chk("align_err",  {15'd0, bus.align_err},  {15'd0, m_align});
        if (rec && bus.data_valid) begin
            got_cyc.push_back(cyc);
            got_dat.push_back(bus.data_out);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // Directed vectors with hand-derived expected outputs after each edge.
    typedef struct {
        logic        rst, en, wr;
        logic [15:0] addr, din;
        logic        chk;
        logic        ev;
        logic [15:0] ed;
        logic        eb;
        logic        ea;
    } vec_t;

    vec_t tbl [$];

    function automatic void mk(input logic r, input logic e, input logic w,
                               input logic [15:0] a, input logic [15:0] d,
                               input logic c, input logic ev, input logic [15:0] ed,
                               input logic eb, input logic ea);
        tbl.push_back('{rst: r, en: e, wr: w, addr: a, din: d, chk: c,
                        ev: ev, ed: ed, eb: eb, ea: ea});
    endfunction

    function automatic void gap();
        for (int i = 0; i < 6; i++) mk(0, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 0, 0);
    endfunction

    logic [15:0] odd_exp;
    logic        odd_err;
    int          first_rd;

    initial begin
        rst         = 1'b1;
        bus.enable  = 1'b0;
        bus.wr      = 1'b0;
        bus.addr    = '0;
        bus.data_in = '0;
        m_valid     = 1'b0;
        m_busy      = 1'b0;
        m_align     = 1'b0;
        m_dout      = 16'h0000;

        // Reset state, with a request presented during reset.
        step(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);

        // Preload every word: word i holds {i, ~i}.
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            step(1'b0, 1'b1, 1'b1, {7'd0, b, 1'b0}, {b, ~b});
        end
        idle(6);

`ifdef MEM_ALIGN_CHECK_EN
        odd_exp = 16'h18E7;
        odd_err = 1'b1;
`else
        odd_exp = 16'h5555;
        odd_err = 1'b0;
`endif
        //  rst en wr addr      din      chk ev  ed       eb ea
        // Write BEEF then read it back: pulse 4 edges after the read.
        mk(0, 1, 1, 16'h0010, 16'hBEEF, 1, 0, 16'h0000, 0, 0);
        mk(0, 1, 0, 16'h0010, 16'h0000, 1, 0, 16'h0000, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hBEEF, 0, 0);
        gap();
        // Read in flight is not disturbed by a following write.
        mk(0, 1, 1, 16'h0020, 16'h1111, 1, 0, 16'hBEEF, 0, 0);
        mk(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'hBEEF, 1, 0);
        mk(0, 1, 1, 16'h0020, 16'h2222, 1, 0, 16'hBEEF, 1, 0);
        mk(0, 1, 0, 16'h0020, 16'h0000, 1, 0, 16'hBEEF, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'hBEEF, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h1111, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h1111, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'h2222, 0, 0);
        gap();
        // Odd-address write: dropped with a flag, or serviced as the even word.
        mk(0, 1, 1, 16'h0031, 16'h5555, 1, 0, 16'h2222, 0, odd_err);
        mk(0, 1, 0, 16'h0030, 16'h0000, 1, 0, 16'h2222, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h2222, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h2222, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, 16'h2222, 1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, odd_exp,  0, 0);
        gap();
        // Aliasing: upper address bits are ignored.
        mk(0, 1, 1, 16'hFE10, 16'hC0DE, 1, 0, odd_exp,  0, 0);
        mk(0, 1, 0, 16'h0010, 16'h0000, 1, 0, odd_exp,  1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, odd_exp,  1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, odd_exp,  1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 0, odd_exp,  1, 0);
        mk(0, 0, 0, 16'h0000, 16'h0000, 1, 1, 16'hC0DE, 0, 0);
        gap();

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].en, tbl[i].wr, tbl[i].addr, tbl[i].din);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_valid", i), {15'd0, bus.data_valid}, {15'd0, tbl[i].ev});
                chk($sformatf("tbl%0d_busy",  i), {15'd0, bus.busy},       {15'd0, tbl[i].eb});
                chk($sformatf("tbl%0d_align", i), {15'd0, bus.align_err},  {15'd0, tbl[i].ea});
                if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), bus.data_out, tbl[i].ed);
            end
        end

        // Eight back-to-back reads return eight consecutive pulses in order.
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 1'b1, 16'h0100 + 16'(2 * i), 16'(i));
        idle(6);
        got_cyc.delete();
        got_dat.delete();
        rec = 1'b1;
        first_rd = cyc + 1;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(2 * i), 16'h0000);
            chk("b2b_busy", {15'd0, bus.busy}, 16'd1);
        end
        idle(8);
        rec = 1'b0;
        chk("b2b_count", 16'(got_cyc.size()), 16'd8);
        if (got_cyc.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("b2b_cyc%0d", i), 16'(got_cyc[i] - first_rd), 16'(L + i));
                chk($sformatf("b2b_dat%0d", i), got_dat[i], 16'(i));
            end
        end

        // Reset with reads in flight: nothing returns, write in reset ignored.
        got_cyc.delete();
        got_dat.delete();
        rec = 1'b1;
        step(1'b0, 1'b1, 1'b0, 16'h0100, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0102, 16'h0000);
        step(1'b0, 1'b1, 1'b0, 16'h0104, 16'h0000);
        idle(1);
        step(1'b1, 1'b1, 1'b1, 16'h0102, 16'hDEAD);
        chk("rst_busy",  {15'd0, bus.busy},       16'd0);
        chk("rst_valid", {15'd0, bus.data_valid}, 16'd0);
        chk("rst_dout",  bus.data_out,            16'h0000);
        idle(8);
        rec = 1'b0;
        chk("rst_no_pulses", 16'(got_cyc.size()), 16'd0);
        step(1'b0, 1'b1, 1'b0, 16'h0102, 16'h0000);
        idle(L);
        chk("rst_retained", bus.data_out, 16'h0001);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 600; i++) begin
            logic r, e, w;
            logic [15:0] a, d;
            r = ($urandom_range(0, 59) == 0);
            e = ($urandom_range(0, 3) != 0);
            w = ($urandom_range(0, 2) == 0);
            a = 16'($urandom);
            d = 16'($urandom);
            step(r, e, w, a, d);
        end
        idle(L + 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_mem_responder.md
MAIN_MEM_RESPONDER -- requirements
Module: main_mem_responder

Interface
REQ-001 Parameter: LATENCY, default 4, read-request-to-data_valid delay in cycles; legal range 1..8.
REQ-002 Parameter: DEPTH_W, default 15, word-index width; array holds 2^DEPTH_W 16-bit words indexed by addr[DEPTH_W:1].
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 enable  input  1  request valid this cycle.
REQ-006 wr  input  1  with enable: 1 = write, 0 = read.
REQ-007 addr  input  16  byte address; word index = addr[DEPTH_W:1].
REQ-008 data_in  input  16  write data.
REQ-009 data_out  output  16  read data, meaningful only when data_valid=1.
REQ-010 data_valid  output  1  one-cycle pulse per returned read word.
REQ-011 busy  output  1  high while any read is in flight.
REQ-012 align_err  output  1  misaligned-request flag (see Configuration).

Function
REQ-013 Block SHALL accept one request every cycle with no backpressure; requester never waits to issue.
REQ-014 Write: enable=1, wr=1 at edge N SHALL update array[word] at edge N; no data_valid generated.
REQ-015 Read: enable=1, wr=0 at edge N SHALL capture array[word] at edge N and present it with data_valid=1 exactly LATENCY cycles later (edge N+LATENCY).
REQ-016 Reads SHALL be fully pipelined: back-to-back reads return back-to-back data_valid pulses in issue order.
REQ-017 Pipeline SHALL be a LATENCY-deep shift register of {valid, data}; stage 0 loads on read, else loads valid=0.
REQ-018 Read data SHALL be array contents at issue edge; a write to the same word while the read is in flight SHALL NOT change the returned value.
REQ-019 Read issued the cycle after a write to the same word SHALL return the new data.
REQ-020 busy SHALL equal the OR of all pipeline valid bits (combinational from registers); busy SHALL NOT include the current-cycle request.
REQ-021 data_out SHALL hold its last value when data_valid=0.
REQ-022 enable=0 SHALL leave array and pipeline inputs idle (stage 0 valid=0); in-flight reads continue draining.
REQ-023 Address wrap: bits above DEPTH_W SHALL be ignored (aliasing), never an error.

Reset
REQ-024 rst=1 at an edge SHALL clear all pipeline valid bits, data_out to 16'h0000, data_valid to 0, busy to 0, align_err to 0.
REQ-025 Reset mid-operation SHALL discard all in-flight reads; no data_valid pulse SHALL follow for requests issued before or during reset.
REQ-026 Requests with enable=1 during rst=1 SHALL be ignored, including writes.
REQ-027 Array contents SHALL NOT be cleared by reset.

Configuration
REQ-028 Macro MEM_ALIGN_CHECK_EN, when defined: request with enable=1 and addr[0]=1 SHALL be dropped (no write, no read issued) and align_err SHALL pulse high one cycle later for one cycle.
REQ-029 Without MEM_ALIGN_CHECK_EN: addr[0] SHALL be ignored, odd addresses serviced as the even word, align_err tied to 0.

Verification
REQ-030 Write 16'hBEEF to addr 16'h0010, read 16'h0010 next cycle -> data_valid=1 with data_out=16'hBEEF exactly 4 cycles after read issue.
REQ-031 Eight back-to-back reads of 16'h0100..16'h010E (preloaded 0..7) -> eight consecutive data_valid cycles, data 0..7 in order; busy high from cycle after first read until last pulse.
REQ-032 Read 16'h0020 (holds 16'h1111), write 16'h2222 to 16'h0020 next cycle -> read returns 16'h1111; subsequent read returns 16'h2222.
REQ-033 Issue 3 reads, assert rst for one cycle 2 cycles later -> no data_valid pulses, busy=0 after reset edge, array data retained.
REQ-034 MEM_ALIGN_CHECK_EN defined: write to 16'h0031 -> align_err pulses next cycle, word at 16'h0030 unchanged; undefined: same write updates word 16'h0030, align_err stays 0.
